// File: rtl/morse_letter_sequencer_if.sv
// Letter request handshake between a requester and the Morse sequencer.
// The requester offers char_code with char_valid; the sequencer answers with char_ready.
interface morse_letter_sequencer_if;
  logic       char_valid;
  logic [2:0] char_code;
  logic       char_ready;

  modport master (
    output char_valid,
    output char_code,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_code,
    output char_ready
  );
endinterface

// File: rtl/morse_letter_sequencer.sv
// FIFO-fed Morse player: queued letters A-H are shifted MSB-first onto one LED,
// one bit per unit, each followed by a timed gap and a char_done pulse.
module morse_letter_sequencer #(
  parameter int TICK_DIV   = 25000000,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_UNITS  = 3
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic abort,
  morse_letter_sequencer_if.slave req,
  output logic led,
  output logic char_done,
  output logic busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_UNITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  function automatic logic [12:0] rom(input logic [2:0] code);
    logic [12:0] p;
    unique case (code)
      3'd0: p = 13'b1011100000000;
      3'd1: p = 13'b1110101010000;
      3'd2: p = 13'b1110101110100;
      3'd3: p = 13'b1110101000000;
      3'd4: p = 13'b1000000000000;
      3'd5: p = 13'b1010111010000;
      3'd6: p = 13'b1110111010000;
      default: p = 13'b1010101000000;
    endcase
    return p;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  mem_q [FIFO_DEPTH];
  logic [2:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  letter_q, letter_d;
  logic [12:0] sr_q, sr_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [GW-1:0] gap_q, gap_d;
  logic        led_q, led_d;
  logic        done_q, done_d;
  logic        push, pop, tick;

  assign req.char_ready = !reset && !abort &&
                          (cnt_q != CW'(FIFO_DEPTH));
  assign push = req.char_valid && req.char_ready;
  assign pop  = (state_q == S_IDLE) && (cnt_q != '0);
  assign tick = (tick_q == TW'(TICK_DIV - 1));

  assign led        = led_q;
  assign char_done  = done_q;
  assign fifo_count = cnt_q;
  assign busy       = (state_q != S_IDLE) || (cnt_q != '0);

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    letter_d = letter_q;
    sr_d     = sr_q;
    tick_d   = tick_q;
    gap_d    = gap_q;
    led_d    = led_q;
    done_d   = 1'b0;

    if (push) begin
      mem_d[wr_q] = req.char_code;
      wr_d = wr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (pop) begin
          letter_d = mem_q[rd_q];
          rd_d     = rd_q + AW'(1);
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        sr_d    = rom(letter_q);
        tick_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        tick_d = tick ? '0 : tick_q + TW'(1);
        if (tick) begin
          led_d = sr_q[12];
          sr_d  = sr_q << 1;
          // Stop as soon as only zeros remain so trailing zeros never play.
          if (sr_q[11:0] == '0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      default: begin
        tick_d = tick ? '0 : tick_q + TW'(1);
        if (tick) begin
          led_d = 1'b0;
          gap_d = gap_q + GW'(1);
          if (gap_q == GW'(GAP_UNITS - 1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      sr_d    = '0;
      tick_d  = '0;
      gap_d   = '0;
      led_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      letter_q <= '0;
      sr_q     <= '0;
      tick_q   <= '0;
      gap_q    <= '0;
      led_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      letter_q <= letter_d;
      sr_q     <= sr_d;
      tick_q   <= tick_d;
      gap_q    <= gap_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Bench for morse_letter_sequencer with TICK_DIV=4, FIFO_DEPTH=4, GAP_UNITS=3.
// Accepted letters go into a scoreboard queue and are matched against the LED.
module tb_morse_letter_sequencer;

  logic       clk;
  logic       reset;
  logic       abort;
  logic       led;
  logic       char_done;
  logic       busy;
  logic [2:0] fifo_count;

  int checks;
  int failures;

  logic [2:0]  sb [$];
  logic [12:0] pat [8] = '{
    13'b1011100000000, 13'b1110101010000,
    13'b1110101110100, 13'b1110101000000,
    13'b1000000000000, 13'b1010111010000,
    13'b1110111010000, 13'b1010101000000
  };

  morse_letter_sequencer_if bus ();

  morse_letter_sequencer #(
    .TICK_DIV  (4),
    .FIFO_DEPTH(4),
    .GAP_UNITS (3)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .abort     (abort),
    .req       (bus),
    .led       (led),
    .char_done (char_done),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_cycle(input logic [2:0] code, output logic rdy);
    bus.char_valid = 1'b1;
    bus.char_code  = code;
    #1;
    rdy = bus.char_ready;
    if (rdy) sb.push_back(code);
    @(negedge clk);
  endtask

  task automatic wait_rise(output logic ok);
    int n;
    n = 0;
    while (led !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 300);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL led_rise_timeout waited=%0d cycles", n);
    end
  endtask

  task automatic play_letter(input string tag);
    logic [2:0]  code;
    logic [12:0] p;
    logic        ok;
    int          len;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard_empty", tag);
      return;
    end
    code = sb.pop_front();
    p = pat[code];
    len = 0;
    for (int i = 0; i < 13; i++)
      if (p[12-i]) len = i + 1;
    wait_rise(ok);
    if (!ok) return;
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (led !== p[12-i] || char_done !== 1'b0) begin
          failures++;
          $display("FAIL %s letter=%0d unit=%0d cyc=%0d led=%b done=%b want led=%b done=0",
                   tag, code, i, c, led, char_done, p[12-i]);
        end
        @(negedge clk);
      end
    end
    for (int g = 0; g < 8; g++) begin
      checks++;
      if (led !== 1'b0 || char_done !== 1'b0) begin
        failures++;
        $display("FAIL %s gap letter=%0d cyc=%0d led=%b done=%b want 0/0",
                 tag, code, g, led, char_done);
      end
      @(negedge clk);
    end
    checks++;
    if (char_done !== 1'b1 || led !== 1'b0) begin
      failures++;
      $display("FAIL %s char_done letter=%0d done=%b led=%b want done=1 led=0",
               tag, code, char_done, led);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (led !== 1'b0 || char_done !== 1'b0 || busy !== 1'b0 ||
        fifo_count !== 3'd0 || bus.char_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s led=%b done=%b busy=%b cnt=%0d rdy=%b want 0 0 0 0 1",
               tag, led, char_done, busy, fifo_count, bus.char_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    abort = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_code  = 3'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.char_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready rdy=%b want 0", bus.char_ready);
    end
    reset = 1'b0;
    #1;
    check_idle("reset_state");
    @(negedge clk);
  endtask

  task automatic test_single_e();
    logic rdy;
    push_cycle(3'd4, rdy);
    bus.char_valid = 1'b0;
    play_letter("single_e");
    @(negedge clk);
    check_idle("single_e_after");
  endtask

  task automatic test_letter_a();
    logic rdy;
    push_cycle(3'd0, rdy);
    bus.char_valid = 1'b0;
    play_letter("letter_a");
    @(negedge clk);
    check_idle("letter_a_after");
  endtask

  task automatic test_back_to_back();
    logic [2:0] codes [6] = '{3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd7};
    logic rdy;
    int   acc;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      push_cycle(codes[i], rdy);
      if (rdy) acc++;
      if (i == 5) begin
        checks++;
        if (rdy !== 1'b0) begin
          failures++;
          $display("FAIL b2b_ready_6th rdy=%b want 0", rdy);
        end
      end
    end
    bus.char_valid = 1'b0;
    #1;
    checks++;
    if (acc != 5 || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL b2b_accept accepted=%0d cnt=%0d want 5 4", acc, fifo_count);
    end
    for (int i = 0; i < 5; i++) play_letter("b2b");
    @(negedge clk);
    check_idle("b2b_after");
  endtask

  task automatic test_abort();
    logic [2:0] codes [4] = '{3'd1, 3'd0, 3'd2, 3'd4};
    logic rdy;
    logic ok;
    int   bad;
    for (int i = 0; i < 4; i++) push_cycle(codes[i], rdy);
    bus.char_valid = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL abort_queued cnt=%0d want 3", fifo_count);
    end
    wait_rise(ok);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    bus.char_valid = 1'b1;
    bus.char_code  = 3'd5;
    #1;
    checks++;
    if (bus.char_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_ready rdy=%b want 0", bus.char_ready);
    end
    @(negedge clk);
    abort = 1'b0;
    bus.char_valid = 1'b0;
    #1;
    check_idle("abort_flush");
    sb.delete();
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (char_done !== 1'b0 || led !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_quiet bad_cycles=%0d want 0", bad);
    end
  endtask

  task automatic test_reset_mid_gap();
    logic rdy;
    logic ok;
    push_cycle(3'd3, rdy);
    bus.char_valid = 1'b0;
    wait_rise(ok);
    repeat (31) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || led !== 1'b0) begin
      failures++;
      $display("FAIL rst_gap_pre busy=%b led=%b want 1 0", busy, led);
    end
    reset = 1'b1;
    bus.char_valid = 1'b1;
    bus.char_code  = 3'd7;
    #1;
    checks++;
    if (bus.char_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_gap_ready rdy=%b want 0", bus.char_ready);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (led !== 1'b0 || char_done !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL rst_gap_outputs led=%b done=%b busy=%b cnt=%0d want 0 0 0 0",
               led, char_done, busy, fifo_count);
    end
    reset = 1'b0;
    bus.char_valid = 1'b0;
    sb.delete();
    #1;
    check_idle("rst_gap_release");
    @(negedge clk);
    push_cycle(3'd6, rdy);
    bus.char_valid = 1'b0;
    play_letter("rst_gap_replay");
    @(negedge clk);
    check_idle("rst_gap_final");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_e();
    test_letter_a();
    test_back_to_back();
    test_abort();
    test_reset_mid_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
